// File: rtl/brief_pkg.sv
// Shared state encoding and sizing helpers for the steered-BRIEF descriptor engine.
package brief_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam int FRAC_DEF   = 10;
  localparam int TRIG_W_DEF = 12;
  localparam int OFF_W      = 7;
  localparam int ROM_DEPTH  = 512;
  localparam int ROM_IDX_W  = 9;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int steps(input int desc_bits, input int lanes);
    return desc_bits / lanes;
  endfunction

endpackage

// File: rtl/brief_pattern_rom.sv
// Fixed 512-entry BRIEF sampling pattern: pair index -> signed offsets (xa, ya, xb, yb).
module brief_pattern_rom
  import brief_pkg::*;
#(
  parameter int PATCH = 31
) (
  input  logic [ROM_IDX_W-1:0]    idx,
  output logic signed [OFF_W-1:0] xa,
  output logic signed [OFF_W-1:0] ya,
  output logic signed [OFF_W-1:0] xb,
  output logic signed [OFF_W-1:0] yb
);

  // Offsets are a modular walk over [-PATCH/2, PATCH/2]; entry 0 is the (15,15) corner for PATCH=31.
  function automatic logic signed [OFF_W-1:0] off(input int n, input int mul, input int add);
    int v;
    v = (n * mul + add) % PATCH - PATCH / 2;
    return OFF_W'(v);
  endfunction

  logic [4*OFF_W-1:0] rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    assign rom[g] = {off(g, 7, PATCH - 1), off(g, 11, PATCH - 1), off(g, 13, 5), off(g, 17, 12)};
  end

  assign {xa, ya, xb, yb} = rom[idx];

endmodule

// File: rtl/brief_engine.sv
// Time-multiplexed steered-BRIEF engine: LANES rotated pixel-pair compares per cycle, STEPS cycles per keypoint.
module brief_engine
  import brief_pkg::*;
#(
  parameter int PATCH     = 31,
  parameter int DESC_BITS = 256,
  parameter int LANES     = 32,
  parameter int TRIG_W    = TRIG_W_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int COOR_W    = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [PATCH*PATCH*8-1:0]      i_patch,
  input  logic signed [TRIG_W-1:0]      i_sin,
  input  logic signed [TRIG_W-1:0]      i_cos,
  input  logic                          i_steer,
  input  logic [COOR_W-1:0]             i_coor_x,
  input  logic [COOR_W-1:0]             i_coor_y,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DESC_BITS-1:0]          o_descriptor,
  output logic [COOR_W-1:0]             o_coor_x,
  output logic [COOR_W-1:0]             o_coor_y
);

  localparam int STEPS    = steps(DESC_BITS, LANES);
  localparam int K_W      = idx_w(STEPS);
  localparam int CW       = idx_w(PATCH);
  localparam int HALF     = PATCH / 2;
  localparam int AW       = OFF_W + TRIG_W + 1;
  localparam int PIX_BITS = PATCH * PATCH * 8;

  state_t                   state_q, state_d;
  logic                     accept;
  logic [PIX_BITS-1:0]      patch_q;
  logic signed [TRIG_W-1:0] sin_q, cos_q;
  logic [COOR_W-1:0]        coor_x_q, coor_y_q;
  logic [K_W-1:0]           k_q;
  logic [DESC_BITS-1:0]     desc_q;
  logic [LANES-1:0]         lane_bits;
  logic signed [AW-1:0]     sin_e, cos_e;

  assign sin_e = AW'(sin_q);
  assign cos_e = AW'(cos_q);

  // Floor-shift the full-precision rotated sum, re-centre, and clamp into the window.
  function automatic logic [CW-1:0] place(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    int                   v;
    logic [CW-1:0]        r;
    sh = acc >>> FRAC;
    v  = int'(sh) + HALF;
    if (v < 0)              r = '0;
    else if (v > PATCH - 1) r = CW'(PATCH - 1);
    else                    r = CW'(v);
    return r;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ROM_IDX_W-1:0]    idx;
    logic signed [OFF_W-1:0] xa, ya, xb, yb;
    logic signed [AW-1:0]    xa_e, ya_e, xb_e, yb_e;
    logic [CW-1:0]           row_a, col_a, row_b, col_b;
    logic [7:0]              pix_a, pix_b;

    assign idx = ROM_IDX_W'(int'(k_q) * LANES + l);

    brief_pattern_rom #(.PATCH(PATCH)) u_rom (
      .idx (idx),
      .xa  (xa),
      .ya  (ya),
      .xb  (xb),
      .yb  (yb)
    );

    assign xa_e  = AW'(xa);
    assign ya_e  = AW'(ya);
    assign xb_e  = AW'(xb);
    assign yb_e  = AW'(yb);
    assign col_a = place(xa_e * cos_e - ya_e * sin_e);
    assign row_a = place(xa_e * sin_e + ya_e * cos_e);
    assign col_b = place(xb_e * cos_e - yb_e * sin_e);
    assign row_b = place(xb_e * sin_e + yb_e * cos_e);
    assign pix_a = patch_q[(int'(row_a) * PATCH + int'(col_a)) * 8 +: 8];
    assign pix_b = patch_q[(int'(row_b) * PATCH + int'(col_b)) * 8 +: 8];
    assign lane_bits[l] = (pix_a > pix_b);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept  = 1'b1;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (k_q == K_W'(STEPS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unsteered requests are folded into the rotation path as an identity rotation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      patch_q  <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
      coor_x_q <= '0;
      coor_y_q <= '0;
      k_q      <= '0;
      desc_q   <= '0;
    end else if (accept) begin
      patch_q  <= i_patch;
      sin_q    <= i_steer ? i_sin : '0;
      cos_q    <= i_steer ? i_cos : TRIG_W'(1 << FRAC);
      coor_x_q <= i_coor_x;
      coor_y_q <= i_coor_y;
      k_q      <= '0;
      desc_q   <= '0;
    end else if (state_q == S_COMPUTE) begin
      desc_q[int'(k_q) * LANES +: LANES] <= lane_bits;
      k_q <= k_q + K_W'(1);
    end
  end

  assign o_descriptor = desc_q;
  assign o_coor_x     = coor_x_q;
  assign o_coor_y     = coor_y_q;

endmodule

// File: tb/tb_brief_engine.sv
// Self-checking bench for brief_engine: table of directed requests plus handshake and reset sequences.
module tb_brief_engine;

  localparam int PATCH     = 31;
  localparam int DESC_BITS = 256;
  localparam int LANES     = 32;
  localparam int TRIG_W    = 12;
  localparam int FRAC      = 10;
  localparam int COOR_W    = 10;
  localparam int STEPS     = DESC_BITS / LANES;
  localparam int H         = PATCH / 2;
  localparam int D         = 1 << FRAC;

  logic                     i_clk, i_rst_n, i_valid, o_ready, i_steer, o_valid, i_ready;
  logic [PATCH*PATCH*8-1:0] i_patch;
  logic signed [TRIG_W-1:0] i_sin, i_cos;
  logic [COOR_W-1:0]        i_coor_x, i_coor_y, o_coor_x, o_coor_y;
  logic [DESC_BITS-1:0]     o_descriptor;

  int checks = 0;
  int errors = 0;

  brief_engine #(
    .PATCH(PATCH), .DESC_BITS(DESC_BITS), .LANES(LANES),
    .TRIG_W(TRIG_W), .FRAC(FRAC), .COOR_W(COOR_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_patch(i_patch), .i_sin(i_sin), .i_cos(i_cos), .i_steer(i_steer),
    .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .o_valid(o_valid), .i_ready(i_ready),
    .o_descriptor(o_descriptor), .o_coor_x(o_coor_x), .o_coor_y(o_coor_y)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int                   mode;
    logic                 steer;
    int                   s;
    int                   c;
    int                   cx;
    int                   cy;
    logic [DESC_BITS-1:0] exp_desc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [DESC_BITS-1:0] got, input logic [DESC_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int pat(input int n, input int which);
    int mul, add;
    case (which)
      0:       begin mul = 7;  add = PATCH - 1; end
      1:       begin mul = 11; add = PATCH - 1; end
      2:       begin mul = 13; add = 5;         end
      default: begin mul = 17; add = 12;        end
    endcase
    return (n * mul + add) % PATCH - H;
  endfunction

  // 0: flat 0x80, 1: column ramp, 2: row ramp, 3: scrambled values spanning 0..255
  function automatic int pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 128;
      1:       return c;
      2:       return r;
      default: return (r * 37 + c * 11) % 256;
    endcase
  endfunction

  function automatic logic [PATCH*PATCH*8-1:0] mk_patch(input int mode);
    logic [PATCH*PATCH*8-1:0] p;
    p = '0;
    for (int r = 0; r < PATCH; r++)
      for (int c = 0; c < PATCH; c++)
        p[(r * PATCH + c) * 8 +: 8] = 8'(pix(mode, r, c));
    return p;
  endfunction

  function automatic int fl(input int a);
    int q;
    q = a / D;
    if ((a % D) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > PATCH - 1) return PATCH - 1;
    return v;
  endfunction

  function automatic logic [DESC_BITS-1:0] model(input int mode, input int s, input int c);
    logic [DESC_BITS-1:0] d;
    int ax, ay, bx, by;
    d = '0;
    for (int n = 0; n < DESC_BITS; n++) begin
      ax = clampc(fl(pat(n, 0) * c - pat(n, 1) * s) + H);
      ay = clampc(fl(pat(n, 0) * s + pat(n, 1) * c) + H);
      bx = clampc(fl(pat(n, 2) * c - pat(n, 3) * s) + H);
      by = clampc(fl(pat(n, 2) * s + pat(n, 3) * c) + H);
      d[n] = pix(mode, ay, ax) > pix(mode, by, bx);
    end
    return d;
  endfunction

  // 0: xa > xb, 1: ya < yb, 2: xa < xb
  function automatic logic [DESC_BITS-1:0] closed(input int kind);
    logic [DESC_BITS-1:0] d;
    d = '0;
    for (int n = 0; n < DESC_BITS; n++) begin
      case (kind)
        0:       d[n] = pat(n, 0) > pat(n, 2);
        1:       d[n] = pat(n, 1) < pat(n, 3);
        default: d[n] = pat(n, 0) < pat(n, 2);
      endcase
    end
    return d;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int lat;
    i_patch  = mk_patch(v.mode);
    i_steer  = v.steer;
    i_sin    = TRIG_W'(v.s);
    i_cos    = TRIG_W'(v.c);
    i_coor_x = COOR_W'(v.cx);
    i_coor_y = COOR_W'(v.cy);
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chki({tag, "_busy"}, int'(o_ready), 0);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chki({tag, "_latency"}, lat, STEPS);
    chk({tag, "_desc"}, o_descriptor, v.exp_desc);
    chki({tag, "_coor_x"}, int'(o_coor_x), v.cx);
    chki({tag, "_coor_y"}, int'(o_coor_y), v.cy);
  endtask

  task automatic release_out(input string tag);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chki({tag, "_ready_after"}, int'(o_ready), 1);
    chki({tag, "_valid_after"}, int'(o_valid), 0);
  endtask

  initial begin
    int seen;
    vecs[0] = '{0, 1'b0, 0,    0,     100,  37,  '0};
    vecs[1] = '{1, 1'b1, 0,    1024,  1,    2,   closed(0)};
    vecs[2] = '{1, 1'b0, 500,  -300,  1023, 0,   closed(0)};
    vecs[3] = '{1, 1'b1, 1024, 0,     3,    4,   closed(1)};
    vecs[4] = '{3, 1'b1, 724,  724,   511,  512, model(3, 724, 724)};
    vecs[5] = '{2, 1'b1, 1024, 0,     7,    8,   closed(0)};
    vecs[6] = '{1, 1'b1, 0,    -1024, 9,    10,  closed(2)};
    vecs[7] = '{3, 1'b1, -512, 887,   222,  333, model(3, -512, 887)};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_steer = 1'b0;
    i_sin = '0; i_cos = '0; i_coor_x = '0; i_coor_y = '0; i_patch = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chki("reset_ready", int'(o_ready), 1);
    chki("reset_valid", int'(o_valid), 0);
    chk("reset_desc", o_descriptor, '0);
    chki("reset_coor_x", int'(o_coor_x), 0);
    chki("reset_coor_y", int'(o_coor_y), 0);

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      if (i == 4) begin
        // pair 0 point a=(15,15) at 45 deg lands on clamped row 30, col 15 (pixel 251) vs b at row 5, col 10 (pixel 39)
        chki("corner45_bit0", int'(o_descriptor[0]), 1);
      end
      release_out($sformatf("vec%0d", i));
    end

    apply(vecs[7], "vec7");
    for (int c = 0; c < 10; c++) begin
      i_valid  = (c % 3 == 0);
      i_patch  = mk_patch(0);
      i_steer  = 1'b0;
      i_coor_x = COOR_W'(5);
      i_coor_y = COOR_W'(6);
      @(posedge i_clk); #1;
      chk("hold_desc", o_descriptor, vecs[7].exp_desc);
      chki("hold_valid", int'(o_valid), 1);
      chki("hold_coor_x", int'(o_coor_x), vecs[7].cx);
      chki("hold_coor_y", int'(o_coor_y), vecs[7].cy);
    end
    i_valid = 1'b0;
    release_out("hold");
    apply(vecs[3], "b2b");
    release_out("b2b");

    i_patch = mk_patch(1); i_steer = 1'b1; i_sin = '0; i_cos = TRIG_W'(1024);
    i_coor_x = COOR_W'(9); i_coor_y = COOR_W'(9); i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chki("midrst_ready", int'(o_ready), 1);
    chki("midrst_valid", int'(o_valid), 0);
    chk("midrst_desc", o_descriptor, '0);
    chki("midrst_coor_x", int'(o_coor_x), 0);
    seen = 0;
    repeat (12) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) seen = 1;
    end
    chki("midrst_no_valid", seen, 0);
    apply(vecs[4], "recover");
    release_out("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brief_engine.md
# brief_engine

Parametrised, time-multiplexed steered-BRIEF descriptor engine for the ORB front end. It sits between the orientation stage and the descriptor FIFO / matcher. Per keypoint it accepts one PATCH×PATCH pixel window plus sin/cos of the keypoint angle over a valid/ready handshake. It rotates the sampling pattern, evaluates DESC_BITS pixel-pair comparisons at LANES per cycle, and returns the descriptor with its coordinates over a second valid/ready handshake.

## Interface
- PATCH, 31: window side in pixels; odd, 7..63.
- DESC_BITS, 256: descriptor length; multiple of LANES, ≤ 512.
- LANES, 32: comparisons evaluated per cycle.
- TRIG_W, 12: signed width of sin/cos.
- FRAC, 10: fractional bits of sin/cos (1.0 = 2^FRAC).
- COOR_W, 10: keypoint coordinate width.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low; clock i_clk.
- i_valid  in  1  request valid.
- o_ready  out  1  engine can accept a request.
- i_patch  in  PATCH·PATCH·8  pixel (r,c) at bits [(r·PATCH+c)·8 +: 8], unsigned.
- i_sin, i_cos  in  TRIG_W  signed Q(FRAC).
- i_steer  in  1  1 = rotate pattern; 0 = unrotated BRIEF (sin/cos ignored).
- i_coor_x, i_coor_y  in  COOR_W  keypoint coordinates, passed through.
- o_valid  out  1  descriptor valid.
- i_ready  in  1  downstream accepts.
- o_descriptor  out  DESC_BITS  result.
- o_coor_x, o_coor_y  out  COOR_W  coordinates of the result.

## Operation
- FSM: IDLE → COMPUTE → DONE → IDLE.
- IDLE: o_ready=1. When i_valid=1, capture patch, sin, cos, steer and coords; clear the descriptor; reset step counter k=0; go to COMPUTE. When i_steer=0, capture cos=2^FRAC and sin=0.
- COMPUTE: o_ready=0. Lanes l=0..LANES-1 handle pair index n=k·LANES+l. Pattern offsets (xa,ya,xb,yb) are signed in ±PATCH/2.
  - xa' = (xa·cos − ya·sin) >>> FRAC and ya' = (xa·sin + ya·cos) >>> FRAC, with full-precision products and sum, arithmetic (floor) shift. Same for b.
  - Add PATCH/2, then saturate to [0, PATCH−1].
  - bit n = pixel(ya',xa') > pixel(yb',xb'), unsigned compare.
  - After k=STEPS−1 (STEPS=DESC_BITS/LANES), go to DONE.
- DONE: o_valid=1; o_descriptor and coords are stable until i_ready=1. On that cycle go to IDLE.
- i_valid while o_ready=0 is ignored; the input is not captured.
- Reset value of every output: o_ready=1, o_valid=0, o_descriptor=0, o_coor_x=o_coor_y=0. Reset mid-operation abandons the request; the FSM returns to IDLE.
- The descriptor register is written only in COMPUTE. Bits not yet computed read 0.

## Timing
- Accept happens at edge t (i_valid·o_ready). COMPUTE occupies edges t+1..t+STEPS, and o_valid rises after edge t+STEPS. Default latency is 8 cycles.
- o_valid·i_ready at edge u gives o_ready=1 after u. Minimum request spacing is STEPS+2 cycles.
- Rotation, the pattern mux and the compare are combinational within one COMPUTE cycle. The only registered state is the captured inputs, k, the state and the descriptor.

## Structure
- Package brief_pkg: state encoding, FRAC/TRIG_W defaults, offset width (signed 7 bits), and STEPS/index-width helpers ($clog2).
- Sub-module brief_pattern_rom: takes a pair index and returns signed xa, ya, xb, yb. The table holds 512 fixed entries, and the engine uses the first DESC_BITS. Instantiate LANES copies, or one wide-read copy indexed by k.

## Test plan
- Reset asserted, then released → o_ready=1, o_valid=0, o_descriptor=0 and coords=0. Reset asserted at k=3 of a request → o_valid stays 0 and o_ready=1 on the next cycle.
- All pixels 0x80, steer=0, coords (100,37) → after 8 cycles o_valid=1, descriptor=0, o_coor=(100,37).
- Pixel(r,c)=c, steer=1, cos=1024, sin=0 → bit n = (xa_n > xb_n) for every n. The result must equal the steer=0 result.
- Pixel(r,c)=c, steer=1, sin=1024, cos=0 (90°) → bit n = (ya_n < yb_n).
- 45°, cos=sin=724, pattern point (15,15) → y' floors to 21; after the +15 centre offset (row 36) it clamps to row 30; x' = 0 maps to column 15. The bench model must match with no out-of-range index.
- Hold i_ready=0 for 10 cycles after o_valid and pulse i_valid meanwhile → outputs stable, no capture. After the i_ready handshake, the next request is accepted on the first cycle in IDLE.
